// File: rtl/diag_stim_sched.sv
`default_nettype none
// ============================================================================
// Module   : diag_stim_sched
// Purpose  : Multi-channel square-wave stimulus scheduler. Each channel
//            toggles with a programmable start delay and half-period inside
//            one bounded run window; done flags the end of the window.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            cfg_we/sel/half/dly - per-channel config write (IDLE/DONE only)
//            start, run_len    - begin a run of run_len cycles (run_len != 0)
//            stop              - abort the current run
//            stim, edge_p      - stimulus levels and one-cycle change pulses
//            busy, done        - run in progress / run finished
// Revision : 1.0 - initial release
// ============================================================================
module diag_stim_sched #(
  parameter  int SELW = 2,
  parameter  int CW   = 8,
  parameter  int TW   = 16,
  localparam int NCH  = 2**SELW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [SELW-1:0] cfg_sel,
  input  logic [CW-1:0]   cfg_half,
  input  logic [CW-1:0]   cfg_dly,
  input  logic            start,
  input  logic            stop,
  input  logic [TW-1:0]   run_len,
  output logic [NCH-1:0]  stim,
  output logic [NCH-1:0]  edge_p,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]  half_cfg [NCH];
  logic [CW-1:0]  dly_cfg  [NCH];
  // Half-period snapshot taken at start, so a config write landing on the
  // start edge cannot leak into the period reloads of the current run.
  logic [CW-1:0]  run_half [NCH];
  logic [CW-1:0]  cnt      [NCH];
  // Delay and period phases are counted separately so d+h never overflows.
  logic [NCH-1:0] in_dly;
  logic [TW-1:0]  run_cnt;
  logic [NCH-1:0] tog;

  logic accept;
  logic finish_run;

  assign accept     = (state != S_RUN) && start && (run_len != '0);
  // Expiry and stop both end the run on this edge and suppress its toggles.
  assign finish_run = (state == S_RUN) && (stop || (run_cnt == TW'(1)));

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tog[i] = (state == S_RUN) && (run_half[i] != '0) && !in_dly[i] &&
               (cnt[i] == CW'(1));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (finish_run) state_nxt = S_DONE;
      S_DONE:  if (accept) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Configuration and per-channel datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        half_cfg[i] <= '0;
        dly_cfg[i]  <= '0;
        run_half[i] <= '0;
        cnt[i]      <= '0;
      end
      in_dly  <= '0;
      run_cnt <= '0;
      stim    <= '0;
      edge_p  <= '0;
    end else begin
      edge_p <= '0;

      if (cfg_we && (state != S_RUN)) begin
        half_cfg[cfg_sel] <= cfg_half;
        dly_cfg[cfg_sel]  <= cfg_dly;
      end

      if (accept) begin
        run_cnt <= run_len;
        stim    <= '0;
        for (int i = 0; i < NCH; i++) begin
          run_half[i] <= half_cfg[i];
          in_dly[i]   <= (dly_cfg[i] != '0);
          cnt[i]      <= (dly_cfg[i] != '0) ? dly_cfg[i] : half_cfg[i];
        end
      end else if ((state == S_RUN) && !finish_run) begin
        run_cnt <= run_cnt - TW'(1);
        stim    <= stim ^ tog;
        edge_p  <= tog;
        for (int i = 0; i < NCH; i++) begin
          if (in_dly[i]) begin
            if (cnt[i] == CW'(1)) begin
              in_dly[i] <= 1'b0;
              cnt[i]    <= run_half[i];
            end else begin
              cnt[i] <= cnt[i] - CW'(1);
            end
          end else if (run_half[i] != '0) begin
            if (cnt[i] == CW'(1)) begin
              cnt[i] <= run_half[i];
            end else begin
              cnt[i] <= cnt[i] - CW'(1);
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_diag_stim_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_diag_stim_sched
// Purpose  : Self-checking bench for diag_stim_sched. Expected waveforms come
//            from a closed-form toggle-count model per channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_diag_stim_sched;
  localparam int SELW = 2;
  localparam int CW   = 8;
  localparam int TW   = 16;
  localparam int NCH  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [SELW-1:0] cfg_sel;
  logic [CW-1:0]   cfg_half;
  logic [CW-1:0]   cfg_dly;
  logic            start;
  logic            stop;
  logic [TW-1:0]   run_len;
  logic [NCH-1:0]  stim;
  logic [NCH-1:0]  edge_p;
  logic            busy;
  logic            done;

  diag_stim_sched #(.SELW(SELW), .CW(CW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_half(cfg_half), .cfg_dly(cfg_dly), .start(start), .stop(stop),
    .run_len(run_len), .stim(stim), .edge_p(edge_p), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_half[NCH];
  int m_dly[NCH];
  int s_half[NCH];
  int s_dly[NCH];
  int last_togs[NCH];

  // Toggles of a channel over edges E0+1 .. E0+k (no run-end applied).
  function automatic int tog_count(int h, int d, int k);
    if (h == 0 || k < d + h) return 0;
    return (k - d) / h;
  endfunction

  task automatic write_cfg(input int sel, input int h, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = SELW'(sel); cfg_half = CW'(h); cfg_dly = CW'(d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_half[sel] = h;
    m_dly[sel]  = d;
  endtask

  // One run from start through extra cycles after its end; optional stop at
  // edge E0+stop_k, optional config write on the start edge (sw_*), optional
  // config write during RUN (rw_en) which must have no effect.
  task automatic run_scenario(input int rl, input int stop_k, input int extra,
                              input bit sw_en, input int sw_sel, input int sw_h,
                              input int sw_d, input bit rw_en);
    int kend;
    int kk;
    logic [NCH-1:0] e_stim;
    logic [NCH-1:0] e_edge;
    kend = (stop_k > 0 && stop_k < rl) ? stop_k : rl;
    for (int i = 0; i < NCH; i++) begin
      s_half[i] = m_half[i];
      s_dly[i]  = m_dly[i];
      last_togs[i] = 0;
    end
    @(negedge clk);
    start = 1'b1; run_len = TW'(rl);
    if (sw_en) begin
      cfg_we = 1'b1; cfg_sel = SELW'(sw_sel); cfg_half = CW'(sw_h); cfg_dly = CW'(sw_d);
    end
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    if (sw_en) begin
      m_half[sw_sel] = sw_h;
      m_dly[sw_sel]  = sw_d;
    end
    for (int k = 0; k <= kend + extra; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      kk = (k < kend) ? k : kend - 1;
      for (int i = 0; i < NCH; i++) begin
        e_stim[i] = (tog_count(s_half[i], s_dly[i], kk) % 2) == 1;
        e_edge[i] = (k >= 1) && (k < kend) &&
                    (tog_count(s_half[i], s_dly[i], k) != tog_count(s_half[i], s_dly[i], k - 1));
      end
      n_checks++;
      if (stim !== e_stim) begin
        n_fail++;
        $display("FAIL stim k=%0d actual=%b expected=%b", k, stim, e_stim);
      end
      n_checks++;
      if (edge_p !== e_edge) begin
        n_fail++;
        $display("FAIL edge_p k=%0d actual=%b expected=%b", k, edge_p, e_edge);
      end
      n_checks++;
      if (busy !== (k < kend)) begin
        n_fail++;
        $display("FAIL busy k=%0d actual=%b expected=%b", k, busy, (k < kend));
      end
      n_checks++;
      if (done !== (k >= kend)) begin
        n_fail++;
        $display("FAIL done k=%0d actual=%b expected=%b", k, done, (k >= kend));
      end
      for (int i = 0; i < NCH; i++) if (edge_p[i] === 1'b1) last_togs[i]++;
      stop = (stop_k > 0 && k == stop_k - 1);
      if (rw_en && k == 1) begin
        cfg_we = 1'b1; cfg_sel = '0; cfg_half = CW'(7); cfg_dly = CW'(2);
      end else begin
        cfg_we = 1'b0;
      end
    end
    stop = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_half = '0; cfg_dly = '0;
    start = 1'b0; stop = 1'b0; run_len = '0;
    for (int i = 0; i < NCH; i++) begin m_half[i] = 0; m_dly[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({stim, edge_p, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs actual=%b expected=0", {stim, edge_p, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    // run_len == 0 start is ignored
    @(negedge clk); start = 1'b1; run_len = '0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stim !== '0) begin
      n_fail++;
      $display("FAIL zero_len_idle actual busy=%b done=%b stim=%b required 0/0/0", busy, done, stim);
    end
  endtask

  task automatic test_sync_pair;
    write_cfg(0, 4, 0);
    write_cfg(1, 4, 0);
    run_scenario(100, 0, 3, 1'b0, 0, 0, 0, 1'b0);
    n_checks++;
    if (last_togs[0] != 24 || last_togs[1] != 24) begin
      n_fail++;
      $display("FAIL sync_pair_count actual=%0d,%0d required=24,24", last_togs[0], last_togs[1]);
    end
  endtask

  task automatic test_delay;
    write_cfg(0, 0, 0);
    write_cfg(1, 0, 0);
    write_cfg(2, 1, 20);
    write_cfg(3, 0, 0);
    run_scenario(30, 0, 2, 1'b0, 0, 0, 0, 1'b0);
    n_checks++;
    if (last_togs[2] != 9 || last_togs[3] != 0) begin
      n_fail++;
      $display("FAIL delay_count actual=%0d,%0d required=9,0", last_togs[2], last_togs[3]);
    end
  endtask

  task automatic test_suppress;
    write_cfg(2, 0, 0);
    write_cfg(0, 5, 0);
    run_scenario(10, 0, 4, 1'b0, 0, 0, 0, 1'b0);
    n_checks++;
    if (stim[0] !== 1'b1 || last_togs[0] != 1) begin
      n_fail++;
      $display("FAIL suppress_end actual stim0=%b togs=%0d required 1/1", stim[0], last_togs[0]);
    end
  endtask

  task automatic test_stop;
    write_cfg(0, 3, 0);
    run_scenario(50, 7, 3, 1'b0, 0, 0, 0, 1'b1);
    n_checks++;
    if (last_togs[0] != 2) begin
      n_fail++;
      $display("FAIL stop_count actual=%0d required=2", last_togs[0]);
    end
    // The RUN-time write must not have changed ch0 (still half=3).
    run_scenario(12, 0, 1, 1'b0, 0, 0, 0, 1'b0);
    n_checks++;
    if (last_togs[0] != 3) begin
      n_fail++;
      $display("FAIL run_write_ignored actual=%0d required=3", last_togs[0]);
    end
  endtask

  task automatic test_zero_len_done;
    logic [NCH-1:0] held;
    held = stim;
    @(negedge clk); start = 1'b1; run_len = '0;
    @(posedge clk); #1; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || stim !== held || edge_p !== '0) begin
      n_fail++;
      $display("FAIL zero_len_done actual busy=%b done=%b stim=%b required 0/1/%b", busy, done, stim, held);
    end
  endtask

  task automatic test_back_to_back;
    // ch0 is half=3; the start-edge write of half=5 must apply only next run.
    run_scenario(20, 0, 0, 1'b1, 0, 5, 0, 1'b0);
    n_checks++;
    if (last_togs[0] != 6) begin
      n_fail++;
      $display("FAIL same_cycle_old actual=%0d required=6", last_togs[0]);
    end
    run_scenario(20, 0, 1, 1'b0, 0, 0, 0, 1'b0);
    n_checks++;
    if (last_togs[0] != 3) begin
      n_fail++;
      $display("FAIL same_cycle_new actual=%0d required=3", last_togs[0]);
    end
  endtask

  task automatic test_random;
    int rl;
    int sk;
    // Boundary: maximal delay plus maximal half-period.
    write_cfg(0, 0, 0);
    write_cfg(3, 255, 255);
    run_scenario(520, 0, 1, 1'b0, 0, 0, 0, 1'b0);
    n_checks++;
    if (last_togs[3] != 1) begin
      n_fail++;
      $display("FAIL max_delay_count actual=%0d required=1", last_togs[3]);
    end
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < NCH; c++) write_cfg(c, $urandom_range(0, 6), $urandom_range(0, 12));
      rl = $urandom_range(1, 60);
      sk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, rl) : 0;
      run_scenario(rl, sk, 2, 1'b0, 0, 0, 0, 1'b0);
    end
  endtask

  task automatic test_async_reset;
    write_cfg(0, 3, 0);
    @(negedge clk); start = 1'b1; run_len = TW'(40);
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stim, edge_p, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset actual=%b expected=0", {stim, edge_p, busy, done});
    end
    for (int i = 0; i < NCH; i++) begin m_half[i] = 0; m_dly[i] = 0; end
    @(negedge clk); rst_n = 1'b1;
    run_scenario(20, 0, 1, 1'b0, 0, 0, 0, 1'b0);
    n_checks++;
    if (last_togs[0] != 0 || last_togs[1] != 0 || last_togs[2] != 0 || last_togs[3] != 0) begin
      n_fail++;
      $display("FAIL cfg_cleared actual=%0d,%0d,%0d,%0d required=0", last_togs[0], last_togs[1], last_togs[2], last_togs[3]);
    end
  endtask

  initial begin
    test_reset();
    test_sync_pair();
    test_delay();
    test_suppress();
    test_stop();
    test_zero_len_done();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
